// File: rtl/orb_pkg.sv
// Shared sizing defaults for the orbital-word write arbiter.
package orb_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 12;
    localparam int DEF_NREQ   = 3;

    // The bank bit sits directly above the requester address in ram_addr.
    localparam int BANK_BIT   = DEF_ADDR_W;

    // Width of a requester index, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/orb_wr_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant of the first pending slot after the pointer.
module rr_pick
    import orb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int PTR_W = idx_width(DEF_NREQ)
) (
    input  logic [NREQ-1:0]  pending,
    input  logic [PTR_W-1:0] pointer,
    output logic [NREQ-1:0]  grant
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // Walk the slots starting just after the pointer and take the first pending one.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int step = 1; step <= NREQ; step++) begin
            idx = PTR_W'((int'(pointer) + step) % NREQ);
            if (!found && pending[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/orb_wr_arbiter.sv
// Multi-requester write arbiter for the shared orbital frame RAM.
module orb_wr_arbiter
    import orb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREQ   = DEF_NREQ
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          we_i,
    input  logic [NREQ*ADDR_W-1:0]   addr_i,
    input  logic [NREQ*DATA_W-1:0]   data_i,
    input  logic                     bank_sw,
    input  logic                     ovf_clr,
    output logic                     ram_we,
    output logic [ADDR_W:0]          ram_addr,
    output logic [DATA_W-1:0]        ram_data,
    output logic [NREQ-1:0]          ovf,
    output logic                     busy
);

    localparam int PTR_W = idx_width(NREQ);

    logic                bank_meta;
    logic                bank_sync;
    logic [NREQ-1:0]     we_prev;
    logic [NREQ-1:0]     rise;
    logic [NREQ-1:0]     pending;
    logic [NREQ-1:0]     pending_next;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     drop;
    logic [NREQ-1:0]     capture;
    logic [NREQ-1:0]     ovf_next;
    logic [NREQ-1:0]     slot_bank;
    logic [ADDR_W-1:0]   slot_addr [NREQ];
    logic [DATA_W-1:0]   slot_data [NREQ];
    logic [PTR_W-1:0]    pointer;
    logic [PTR_W-1:0]    grant_idx;
    logic                any_grant;

    assign rise = we_i & ~we_prev;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .pending (pending),
        .pointer (pointer),
        .grant   (grant)
    );

    // Turn the one-hot grant into an index for the output mux and pointer.
    always_comb begin
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                grant_idx = PTR_W'(k);
                any_grant = 1'b1;
            end
        end
    end

    // A new request lands unless its slot is still occupied and not being drained now.
    always_comb begin
        pending_next = pending & ~grant;
        drop         = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (rise[k]) begin
                if (pending[k] && !grant[k]) begin
                    drop[k] = 1'b1;
                end else begin
                    pending_next[k] = 1'b1;
                end
            end
        end
    end

    assign capture  = rise & ~drop;
    assign ovf_next = (ovf_clr ? '0 : ovf) | drop;

    // Control state: bank synchronizer, strobe history, pending flags and pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_meta <= 1'b0;
            bank_sync <= 1'b0;
            we_prev   <= '0;
            pending   <= '0;
            pointer   <= PTR_W'(NREQ - 1);
        end else begin
            bank_meta <= bank_sw;
            bank_sync <= bank_meta;
            we_prev   <= we_i;
            pending   <= pending_next;
            if (any_grant) begin
                pointer <= grant_idx;
            end
        end
    end

    // Slot storage: address, data and bank frozen at capture time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_bank <= '0;
            for (int k = 0; k < NREQ; k++) begin
                slot_addr[k] <= '0;
                slot_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (capture[k]) begin
                    slot_bank[k] <= bank_sync;
                    slot_addr[k] <= addr_i[k*ADDR_W +: ADDR_W];
                    slot_data[k] <= data_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Registered RAM port, overflow flags and busy indication.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
            ovf      <= '0;
            busy     <= 1'b0;
        end else begin
            ram_we <= any_grant;
            if (any_grant) begin
                ram_addr <= {slot_bank[grant_idx], slot_addr[grant_idx]};
                ram_data <= slot_data[grant_idx];
            end
            ovf  <= ovf_next;
            busy <= |pending_next;
        end
    end

endmodule

// File: tb/tb_orb_wr_arbiter.sv
// Self-checking bench for orb_wr_arbiter: cycle model plus directed scenarios.
module tb_orb_wr_arbiter;
    import orb_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;
    localparam int NR = DEF_NREQ;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     we_i;
    logic [NR*AW-1:0]  addr_i;
    logic [NR*DW-1:0]  data_i;
    logic              bank_sw;
    logic              ovf_clr;
    logic              ram_we;
    logic [AW:0]       ram_addr;
    logic [DW-1:0]     ram_data;
    logic [NR-1:0]     ovf;
    logic              busy;

    int checks = 0;
    int errors = 0;

    orb_wr_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .NREQ   (NR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .bank_sw  (bank_sw),
        .ovf_clr  (ovf_clr),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ovf      (ovf),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: each requester owns one mailbox; a grant picks the
    // next occupied mailbox in circular order after the last one served.
    logic [NR-1:0]  m_valid;
    logic [NR-1:0]  m_prev;
    logic [NR-1:0]  m_bank;
    logic [AW-1:0]  m_addr [NR];
    logic [DW-1:0]  m_data [NR];
    int             m_last;
    int             m_win;
    int             m_cand;
    logic           m_s1;
    logic           m_s2;
    logic           exp_we;
    logic [AW:0]    exp_addr;
    logic [DW-1:0]  exp_data;
    logic [NR-1:0]  exp_ovf;
    logic           exp_busy;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_valid  = '0;
                m_prev   = '0;
                m_bank   = '0;
                m_last   = NR - 1;
                m_s1     = 1'b0;
                m_s2     = 1'b0;
                exp_we   = 1'b0;
                exp_addr = '0;
                exp_data = '0;
                exp_ovf  = '0;
                exp_busy = 1'b0;
            end else begin
                m_win = -1;
                for (int s = 1; s <= NR; s++) begin
                    m_cand = (m_last + s) % NR;
                    if (m_win < 0 && m_valid[m_cand]) m_win = m_cand;
                end
                exp_we = (m_win >= 0);
                if (m_win >= 0) begin
                    exp_addr = {m_bank[m_win], m_addr[m_win]};
                    exp_data = m_data[m_win];
                    m_valid[m_win] = 1'b0;
                    m_last = m_win;
                end
                if (ovf_clr) exp_ovf = '0;
                for (int k = 0; k < NR; k++) begin
                    if (we_i[k] && !m_prev[k]) begin
                        if (m_valid[k]) begin
                            exp_ovf[k] = 1'b1;
                        end else begin
                            m_valid[k] = 1'b1;
                            m_bank[k]  = m_s2;
                            m_addr[k]  = addr_i[k*AW +: AW];
                            m_data[k]  = data_i[k*DW +: DW];
                        end
                    end
                    m_prev[k] = we_i[k];
                end
                exp_busy = |m_valid;
                m_s2 = m_s1;
                m_s1 = bank_sw;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: every falling edge the DUT must agree with the model.
    initial begin
        forever begin
            @(negedge clk);
            check_output("mon_ram_we", 32'(ram_we), 32'(exp_we));
            check_output("mon_ovf", 32'(ovf), 32'(exp_ovf));
            check_output("mon_busy", 32'(busy), 32'(exp_busy));
            if (exp_we || !rst) begin
                check_output("mon_ram_addr", 32'(ram_addr), 32'(exp_addr));
                check_output("mon_ram_data", 32'(ram_data), 32'(exp_data));
            end
        end
    end

    task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr_i[k*AW +: AW] = a;
        data_i[k*DW +: DW] = d;
    endtask

    // Drive strobes and clear for one clock, return at the next falling edge.
    task automatic apply_stimulus(input logic [NR-1:0] we, input logic clr);
        we_i    = we;
        ovf_clr = clr;
        @(negedge clk);
    endtask

    task automatic do_reset();
        we_i    = '0;
        ovf_clr = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        we_i    = '0;
        addr_i  = '0;
        data_i  = '0;
        bank_sw = 1'b0;
        ovf_clr = 1'b0;
        #3 rst = 1'b0;
        #1;
        check_output("rst_ram_we", 32'(ram_we), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        // Single request on requester 1 with bank 1.
        $display("[TB] single request");
        bank_sw = 1'b1;
        apply_stimulus(3'b000, 1'b0);
        apply_stimulus(3'b000, 1'b0);
        set_req(1, 11'h005, 12'h2A4);
        apply_stimulus(3'b010, 1'b0);
        check_output("single_we_early", 32'(ram_we), 32'd0);
        apply_stimulus(3'b010, 1'b0);
        check_output("single_we", 32'(ram_we), 32'd1);
        check_output("single_addr", 32'(ram_addr), 32'h805);
        check_output("single_data", 32'(ram_data), 32'h2A4);
        apply_stimulus(3'b010, 1'b0);
        check_output("single_we_after", 32'(ram_we), 32'd0);
        apply_stimulus(3'b000, 1'b0);

        // Full contention straight after reset.
        $display("[TB] contention");
        bank_sw = 1'b0;
        do_reset();
        for (int k = 0; k < NR; k++) set_req(k, AW'(32'h010 + k), DW'(32'h100 + k));
        apply_stimulus(3'b111, 1'b0);
        check_output("cont_busy0", 32'(busy), 32'd1);
        for (int k = 0; k < NR; k++) begin
            apply_stimulus((k == NR - 1) ? 3'b000 : 3'b111, 1'b0);
            check_output("cont_we", 32'(ram_we), 32'd1);
            check_output("cont_addr", 32'(ram_addr), 32'h010 + k);
            check_output("cont_busy", 32'(busy), (k == NR - 1) ? 32'd0 : 32'd1);
        end
        apply_stimulus(3'b000, 1'b0);
        check_output("cont_idle", 32'(ram_we), 32'd0);

        // Overflow on requester 2, with the clear arriving in the same cycle.
        $display("[TB] overflow");
        do_reset();
        set_req(0, 11'h030, 12'h0A0);
        set_req(1, 11'h031, 12'h0A1);
        set_req(2, 11'h032, 12'h111);
        apply_stimulus(3'b111, 1'b0);
        apply_stimulus(3'b000, 1'b0);
        check_output("ovf_w0", 32'(ram_data), 32'h0A0);
        set_req(0, 11'h030, 12'h0AA);
        set_req(2, 11'h032, 12'h222);
        apply_stimulus(3'b101, 1'b1);
        check_output("ovf_w1", 32'(ram_data), 32'h0A1);
        check_output("ovf_set", 32'(ovf), 32'h4);
        apply_stimulus(3'b000, 1'b0);
        check_output("ovf_w2_addr", 32'(ram_addr), 32'h032);
        check_output("ovf_w2_data", 32'(ram_data), 32'h111);
        apply_stimulus(3'b000, 1'b0);
        check_output("ovf_w0b", 32'(ram_data), 32'h0AA);
        apply_stimulus(3'b000, 1'b0);
        check_output("ovf_sticky", 32'(ovf), 32'h4);
        apply_stimulus(3'b000, 1'b1);
        check_output("ovf_clr", 32'(ovf), 32'h0);
        apply_stimulus(3'b000, 1'b0);

        // Requester 0 re-strobes in the very cycle it is granted.
        $display("[TB] capture on grant");
        do_reset();
        set_req(0, 11'h020, 12'h0C0);
        apply_stimulus(3'b001, 1'b0);
        apply_stimulus(3'b000, 1'b0);
        check_output("cog_prime", 32'(ram_data), 32'h0C0);
        apply_stimulus(3'b000, 1'b0);
        set_req(0, 11'h020, 12'h0C1);
        set_req(1, 11'h021, 12'h1C1);
        apply_stimulus(3'b011, 1'b0);
        apply_stimulus(3'b000, 1'b0);
        check_output("cog_w1", 32'(ram_data), 32'h1C1);
        set_req(0, 11'h020, 12'h0C2);
        apply_stimulus(3'b001, 1'b0);
        check_output("cog_w0_old", 32'(ram_data), 32'h0C1);
        apply_stimulus(3'b000, 1'b0);
        check_output("cog_w0_new", 32'(ram_data), 32'h0C2);
        check_output("cog_ovf", 32'(ovf), 32'h0);
        apply_stimulus(3'b000, 1'b0);

        // Bank flip after capture leaves the captured bank untouched.
        $display("[TB] bank toggle");
        bank_sw = 1'b0;
        do_reset();
        set_req(2, 11'h333, 12'h5A5);
        apply_stimulus(3'b100, 1'b0);
        bank_sw = 1'b1;
        apply_stimulus(3'b000, 1'b0);
        check_output("bank_old_bit", 32'(ram_addr[BANK_BIT]), 32'd0);
        check_output("bank_old_addr", 32'(ram_addr), 32'h333);
        apply_stimulus(3'b000, 1'b0);
        set_req(2, 11'h333, 12'h5A6);
        apply_stimulus(3'b100, 1'b0);
        apply_stimulus(3'b000, 1'b0);
        check_output("bank_new_addr", 32'(ram_addr), 32'hB33);
        check_output("bank_new_data", 32'(ram_data), 32'h5A6);

        // Reset with two pending slots discards them.
        $display("[TB] reset mid-operation");
        bank_sw = 1'b0;
        do_reset();
        for (int k = 0; k < NR; k++) set_req(k, AW'(32'h040 + k), DW'(32'h300 + k));
        apply_stimulus(3'b111, 1'b0);
        apply_stimulus(3'b000, 1'b0);
        check_output("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_output("mid_rst_we", 32'(ram_we), 32'd0);
        check_output("mid_rst_addr", 32'(ram_addr), 32'd0);
        check_output("mid_rst_data", 32'(ram_data), 32'd0);
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(3'b000, 1'b0);
            check_output("mid_quiet", 32'(ram_we), 32'd0);
        end
        set_req(1, 11'h055, 12'h3C3);
        #2 rst = 1'b0;
        we_i = 3'b010;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check_output("held_capture_busy", 32'(busy), 32'd1);
        apply_stimulus(3'b010, 1'b0);
        check_output("held_write", 32'(ram_we), 32'd1);
        check_output("held_data", 32'(ram_data), 32'h3C3);
        apply_stimulus(3'b000, 1'b0);
        apply_stimulus(3'b000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
